// File: rtl/bitonic_pkg.sv
// Shared types for the bitonic sorter front end.
// Defaults, loader state encoding and slot bit-position helper.
package bitonic_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int N_DEF     = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  // LSB position of 0-based slot k in a packed block.
  function automatic int slot_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/bitonic_slot_reg.sv
// One block slot: a WIDTH-bit register with load, pad-load and hold.
// Ports: clk, rst, load/d, pad/pad_value, q.
module bitonic_slot_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             pad,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] pad_value,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (pad) begin
      q <= pad_value;
    end
  end

endmodule

// File: rtl/bitonic_loader.sv
// Serial-in, parallel-out loader feeding the 8-input bitonic network.
// Ports: clk, rst, in_valid/in_data/in_last/in_ready, out_valid/out_ready/out_data/out_count.
module bitonic_loader
  import bitonic_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter int               N         = N_DEF,
  parameter logic [WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [$clog2(N):0]   out_count
);

  localparam int CW = $clog2(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          at_end;

  // Handshake flags come straight from the state register.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == FULL);

  assign accept = in_valid & in_ready;
  assign at_end = in_last | (cnt == CW'(N - 1));

  for (genvar i = 0; i < N; i++) begin : g_slot
    localparam logic [CW-1:0] IDX = CW'(i);
    logic ld;
    logic pd;

    assign ld = accept & (cnt == IDX);
    // Slots past the last real number take the pad value.
    assign pd = accept & in_last & (IDX > cnt);

    bitonic_slot_reg #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .pad      (pd),
      .d        (in_data),
      .pad_value(PAD_VALUE),
      .q        (out_data[slot_lsb(i, WIDTH) +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      cnt       <= '0;
      out_count <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (accept) begin
            if (at_end) begin
              state     <= FULL;
              out_count <= (CW+1)'(cnt) + (CW+1)'(1);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state <= COLLECT;
            cnt   <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bitonic_loader.sv
// Self-checking bench for bitonic_loader.
// Random and directed blocks checked against a queue-based block model.
module tb_bitonic_loader;

  localparam int W = 8;
  localparam int N = 8;
  localparam logic [W-1:0] PAD = 8'h00;

  logic           clk = 0;
  logic           rst = 1;
  logic           in_valid = 0;
  logic [W-1:0]   in_data = '0;
  logic           in_last = 0;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready = 0;
  logic [N*W-1:0] out_data;
  logic [3:0]     out_count;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int first_acc;
  int last_acc;

  logic [W-1:0] vals [16];

  bitonic_loader #(
    .WIDTH(W),
    .N(N),
    .PAD_VALUE(PAD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model: the first n received numbers in order, rest padded.
  function automatic logic [N*W-1:0] exp_block(input int n);
    logic [W-1:0] q[$];
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) q.push_back(k < n ? vals[k] : PAD);
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = q[k];
    return r;
  endfunction

  // Sends vals[0..n-1], last flag on final number if use_last.
  // Ends at the negedge after the final accept and checks the block.
  task automatic feed(input int n, input bit use_last,
                      input int gap, input string tag);
    int t;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 0;
        @(negedge clk);
      end
      in_valid = 1;
      in_data  = vals[i];
      in_last  = use_last && (i == n - 1);
      t = 0;
      while (!in_ready && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (t >= 40) begin
        n_fail++;
        $display("FAIL %s timeout waiting in_ready at item %0d", tag, i);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s early out_valid at item %0d got %b want 0",
                 tag, i, out_valid);
      end
      @(negedge clk);
      if (i == 0) first_acc = cyc;
      if (i == n - 1) last_acc = cyc;
    end
    in_valid = 0;
    in_last  = 0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s out_valid/in_ready got %b/%b want 1/0",
               tag, out_valid, in_ready);
    end
    n_checks++;
    if (out_data !== exp_block(n)) begin
      n_fail++;
      $display("FAIL %s out_data got %h want %h", tag, out_data, exp_block(n));
    end
    n_checks++;
    if (out_count !== 4'(n)) begin
      n_fail++;
      $display("FAIL %s out_count got %0d want %0d", tag, out_count, n);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset flags valid/ready got %b/%b want 0/1",
               out_valid, in_ready);
    end
    n_checks++;
    if (out_data !== '0 || out_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset data/count got %h/%0d want 0/0",
               out_data, out_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < N; k++) vals[k] = W'((k + 1) * 10);
    out_ready = 1;
    feed(N, 0, 0, "b2b");
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_one_cycle valid/ready got %b/%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_pad();
    vals[0] = 5;
    vals[1] = 3;
    vals[2] = 9;
    out_ready = 0;
    feed(3, 1, 0, "pad");
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_hold();
    logic [N*W-1:0] snap;
    for (int k = 0; k < N; k++) vals[k] = W'($urandom);
    out_ready = 0;
    feed(N, 0, 0, "hold");
    snap = out_data;
    for (int c = 0; c < 4; c++) begin
      in_valid = c[0];
      in_data  = W'($urandom);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== snap) begin
        n_fail++;
        $display("FAIL hold cyc %0d valid/ready %b/%b data %h want 1/0 %h",
                 c, out_valid, in_ready, out_data, snap);
      end
    end
    in_valid  = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release valid/ready got %b/%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < N; k++) vals[k] = W'((k + 1) * 10);
    out_ready = 0;
    feed(N, 0, 2, "gaps");
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_abort();
    for (int k = 0; k < 4; k++) vals[k] = W'(8'hA0 + k);
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1;
      in_data  = vals[k];
      @(negedge clk);
    end
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      n_fail++;
      $display("FAIL abort valid/ready/data got %b/%b/%h want 0/1/0",
               out_valid, in_ready, out_data);
    end
    for (int k = 0; k < N; k++) vals[k] = W'(k + 1);
    feed(N, 0, 0, "abort_next");
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_two_blocks();
    int a_last;
    out_ready = 1;
    for (int k = 0; k < N; k++) vals[k] = W'($urandom);
    feed(N, 0, 0, "blk_a");
    a_last = last_acc;
    for (int k = 0; k < N; k++) vals[k] = W'($urandom);
    feed(N, 0, 0, "blk_b");
    n_checks++;
    if (first_acc - a_last < 2) begin
      n_fail++;
      $display("FAIL period gap got %0d want >=2", first_acc - a_last);
    end
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_random();
    int n;
    bit lst;
    for (int b = 0; b < 6; b++) begin
      n   = $urandom_range(1, N);
      lst = (n < N) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) vals[k] = W'($urandom);
      out_ready = 0;
      feed(n, lst, $urandom_range(0, 2), "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_pad();
    test_hold();
    test_gaps();
    test_abort();
    test_two_blocks();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitonic_loader.md
Name: bitonic_loader

Overview:
- Serial-in, parallel-out front end for the 8-input bitonic sorting network.
- Accepts one WIDTH-bit number per cycle over a valid/ready handshake and assembles N numbers into a parallel block.
- Presents the block to the first sorting stage (number_in1..number_in8 order) and holds it until the consumer accepts it.
- Supports early termination with padding, so partial blocks still form a legal N-element input.

Parameters:
- WIDTH, 8, bit width of each number
- N, 8, numbers per block (power of two, 2..16)
- PAD_VALUE, 8'h00, value written to unfilled slots on early termination

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_data is valid this cycle
- in_data  input  WIDTH  incoming number
- in_last  input  1  qualifies in_data as the final number of a block; meaningful only with in_valid
- in_ready  output  1  loader can accept in_data this cycle
- out_valid  output  1  out_data holds a complete block
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  N*WIDTH  packed block; slot k (1-based) at bits [k*WIDTH-1:(k-1)*WIDTH], slot 1 = first number received
- out_count  output  $clog2(N)+1  number of real (non-pad) numbers in the block, 1..N

Behaviour:
- States: COLLECT, FULL. Reset state is COLLECT.
- Reset values: cnt=0, out_valid=0, out_data=0, out_count=0. in_ready=1 (in_ready = state==COLLECT, decoded from the state register, no combinational path from any input).
- COLLECT, accept = in_valid & in_ready:
  - in_data is written to slot cnt+1 and cnt increments.
  - If cnt==N-1 or in_last=1: next state FULL; out_count = cnt+1.
  - On in_last with cnt<N-1, slots cnt+2..N are written to PAD_VALUE in the same edge.
- FULL:
  - out_valid=1, in_ready=0.
  - out_data and out_count are stable while out_valid & ~out_ready.
  - On out_ready: next state COLLECT, cnt=0, out_valid=0. out_data keeps its old value (don't-care) until overwritten.
- No bypass: a number offered in the same cycle as the FULL->COLLECT handoff is not accepted (in_ready=0 that cycle).
- Latency: out_valid rises on the edge that captures the Nth (or last) number, i.e. visible the cycle after that accept. Minimum period per full block is N+1 cycles.
- in_valid=0 in COLLECT: no state change; gaps are allowed anywhere.
- in_last on the Nth number: identical to a full block; no padding, out_count=N.
- out_ready while not FULL: ignored.
- rst asserted mid-collection or mid-hold: partial block discarded, all reset values restored next cycle, no out_valid pulse.
- rst has priority over every other input in the same cycle.
- Datapath is pure register load, no arithmetic. cnt width is $clog2(N) and it never wraps past N-1.

Decomposition:
- Shared package bitonic_pkg: WIDTH/N defaults, state encoding (COLLECT=1'b0, FULL=1'b1), and a slot-index helper function.
- Optional single sub-module bitonic_slot_reg: one WIDTH-bit register with load, pad-load and hold enables, instantiated N times. Control FSM stays in bitonic_loader.

Test Plan:
- Reset, then feed 8 back-to-back numbers 10,20,30,40,50,60,70,80 with out_ready=1 -> out_valid high exactly one cycle, the cycle after the 8th accept. Slot1=10..slot8=80, out_count=8, in_ready low that cycle.
- Feed 5,3,9 with in_last on 9 -> slots = 5,3,9,0,0,0,0,0; out_count=3; out_valid next cycle.
- Full block with out_ready=0 for 4 cycles -> out_valid held, out_data stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> in_ready=1 next cycle, cnt=0.
- Random in_valid gaps (in_valid=1 every third cycle) over 8 numbers -> same block contents as back-to-back; out_valid after the 8th accept only.
- Assert rst after 4 accepted numbers, then send 8 fresh numbers 1..8 -> no output for the aborted block. Next block = 1..8 and out_count=8.
- Two consecutive blocks with out_ready tied high -> second block's first number accepted no earlier than 2 cycles after the first block's 8th accept (N+1 cycle period); both blocks intact.
